// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive-side frame parser.
//   parse_state_t : parser FSM states (SYNC -> CMD -> LEN -> PAY -> CHK)
//   frame_err_t   : per-frame error code reported with frame_done
//   SYNC_BYTE_DEF : default frame start marker
//   decode_len    : LEN byte to word count (8'h00 encodes 256 words)
package uart_pkg;

  typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_PAY, S_CHK} parse_state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_CHK, ERR_TIMEOUT, ERR_OVF} frame_err_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// First-word-fall-through FIFO for parsed payload words.
//   i_clk   : clock
//   i_srst  : synchronous active-high reset (flushes contents)
//   i_push  : write i_din; ignored when full unless a pop happens the same cycle
//   i_din   : {last, data} entry
//   o_full  : no free slot
//   i_pop   : remove head entry; ignored when empty
//   o_dout  : head entry, valid whenever o_empty is low
//   o_empty : no entry stored
module uart_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_dout = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses framed commands from a UART byte stream:
//   SYNC, CMD, LEN, LEN*4 payload bytes, CHK (XOR of CMD..last payload byte).
// Payload is packed little-endian into 32-bit words and buffered in a FWFT FIFO.
//   i_sys_clk/i_sys_rst      : clock, synchronous active-high reset
//   i_rx_valid/i_rx_data     : received byte strobe and value
//   o_cmd_valid              : pulse after the header is parsed
//   o_cmd_code/o_cmd_len     : header fields, held until the next header
//   o_word_valid/_data/_last : FIFO head; i_word_ready accepts it
//   o_frame_done/o_frame_err : pulse at end of frame, with error flag
//   o_err_code               : none/checksum/timeout/overflow, held until next frame_done
//   o_busy                   : parser is inside a frame
module uart_rx_frame_parser import uart_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 400000,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_code,
  output logic [8:0]  o_cmd_len,
  output logic        o_word_valid,
  output logic [31:0] o_word_data,
  output logic        o_word_last,
  input  logic        i_word_ready,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  parse_state_t    r_state;
  parse_state_t    w_state_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_cmd_byte;
  logic [7:0]      r_chk;
  logic [1:0]      r_lane;
  logic [7:0]      r_word;
  logic            r_ovf;
  logic            r_cmd_valid;
  logic [7:0]      r_cmd_code;
  logic [8:0]      r_cmd_len;
  logic            r_frame_done;
  logic            r_frame_err;
  frame_err_t      r_err_code;

  logic            w_timeout;
  logic            w_hdr;
  logic            w_push;
  logic            w_last;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [32:0]     w_din;
  logic [32:0]     w_dout;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state != S_SYNC) && !i_rx_valid && (r_to_cnt == TO_LAST);
  assign w_last    = ({1'b0, r_word} == (r_cmd_len - 9'd1));
  assign w_pop     = ~w_empty & i_word_ready;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) r_state <= S_SYNC;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr        = 1'b0;
    w_push       = 1'b0;
    if (w_timeout) begin
      w_state_next = S_SYNC;
    end else if (i_rx_valid) begin
      case (r_state)
        S_SYNC: if (i_rx_data == SYNC_BYTE) w_state_next = S_CMD;
        S_CMD:  w_state_next = S_LEN;
        S_LEN: begin
          w_state_next = S_PAY;
          w_hdr        = 1'b1;
        end
        S_PAY: begin
          if (r_lane == 2'd3) begin
            w_push = 1'b1;
            if (w_last) w_state_next = S_CHK;
          end
        end
        S_CHK:   w_state_next = S_SYNC;
        default: w_state_next = S_SYNC;
      endcase
    end
  end

  // Inter-byte idle counter; only meaningful inside a frame.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst || i_rx_valid || (r_state == S_SYNC) || w_timeout) r_to_cnt <= '0;
    else                                                             r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  // Payload lanes 0..2 are staged; lane 3 goes straight into the FIFO word.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] r_byte;
      always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
          r_byte <= '0;
        end else if (i_rx_valid && (r_state == S_PAY) && (r_lane == 2'(gi))) begin
          r_byte <= i_rx_data;
        end
      end
    end
  endgenerate

  assign w_din = {w_last, i_rx_data, g_lane[2].r_byte, g_lane[1].r_byte, g_lane[0].r_byte};

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_cmd_byte   <= '0;
      r_chk        <= '0;
      r_lane       <= '0;
      r_word       <= '0;
      r_ovf        <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= '0;
      r_cmd_len    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_cmd_valid  <= w_hdr;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (i_rx_valid) begin
        case (r_state)
          S_CMD: begin
            r_cmd_byte <= i_rx_data;
            r_chk      <= i_rx_data;
          end
          S_LEN: begin
            r_cmd_code <= r_cmd_byte;
            r_cmd_len  <= decode_len(i_rx_data);
            r_chk      <= r_chk ^ i_rx_data;
            r_lane     <= '0;
            r_word     <= '0;
            r_ovf      <= 1'b0;
          end
          S_PAY: begin
            r_chk  <= r_chk ^ i_rx_data;
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) r_word <= r_word + 8'd1;
            // Word is dropped when the FIFO cannot take it; remember for CHK.
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
          end
          S_CHK: begin
            r_frame_done <= 1'b1;
            if (r_ovf) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_OVF;
            end else if (i_rx_data != r_chk) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_CHK;
            end else begin
              r_err_code  <= ERR_NONE;
            end
          end
          default: ;
        endcase
      end
      if (w_timeout) begin
        r_frame_done <= 1'b1;
        r_frame_err  <= 1'b1;
        r_err_code   <= ERR_TIMEOUT;
      end
    end
  end

  uart_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .i_clk   (i_sys_clk),
    .i_srst  (i_sys_rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_empty (w_empty)
  );

  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_code   = r_cmd_code;
  assign o_cmd_len    = r_cmd_len;
  assign o_word_valid = ~w_empty;
  assign o_word_data  = w_empty ? 32'd0 : w_dout[31:0];
  assign o_word_last  = ~w_empty & w_dout[32];
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_busy       = (r_state != S_SYNC);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: stimulus pushes expected
// header/word/frame-end records; a negedge monitor pops and compares them.
module tb_uart_rx_frame_parser;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [8:0]  cmd_len;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_cmds[$];   // {code, len}
  logic [32:0] exp_words[$];  // {last, data}
  logic [2:0]  exp_done[$];   // {frame_err, err_code}
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  uart_rx_frame_parser #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (rst),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_cmd_valid  (cmd_valid),
    .o_cmd_code   (cmd_code),
    .o_cmd_len    (cmd_len),
    .o_word_valid (word_valid),
    .o_word_data  (word_data),
    .o_word_last  (word_last),
    .i_word_ready (word_ready),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_err_code   (err_code),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT output with nothing expected", name);
  endtask

  // Monitor: compare every DUT output event against the scoreboard queues.
  initial begin
    logic [16:0] ec;
    logic [32:0] ew;
    logic [2:0]  ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_valid) begin
          if (exp_cmds.size() == 0) unexpected("cmd_valid");
          else begin
            ec = exp_cmds.pop_front();
            check("cmd_code", 64'(cmd_code), 64'(ec[16:9]));
            check("cmd_len", 64'(cmd_len), 64'(ec[8:0]));
          end
        end
        if (word_valid && word_ready) begin
          if (exp_words.size() == 0) unexpected("word");
          else begin
            ew = exp_words.pop_front();
            check("word", 64'({word_last, word_data}), 64'(ew));
          end
        end
        if (frame_done) begin
          if (exp_done.size() == 0) unexpected("frame_done");
          else begin
            ed = exp_done.pop_front();
            check("frame_end", 64'({frame_err, err_code}), 64'(ed));
          end
        end
      end
    end
  end

  task automatic send_tx();
    while (tx_q.size() != 0) begin
      rx_valid = 1'b1;
      rx_data  = tx_q.pop_front();
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // done_only: wait for frame-end records only (words may be held back by ready=0).
  task automatic wait_sb(input int budget, input bit done_only, input string name);
    int c;
    int pend;
    c = 0;
    pend = done_only ? exp_done.size() : exp_cmds.size() + exp_words.size() + exp_done.size();
    while (pend != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
      pend = done_only ? exp_done.size() : exp_cmds.size() + exp_words.size() + exp_done.size();
    end
    n_checks++;
    if (pend != 0) begin
      n_errors++;
      $display("FAIL %s: %0d records still pending after %0d cycles, required 0", name, pend, budget);
    end
  endtask

  // Frame with payload byte i = seed + i; only the first 'keep' words are
  // expected out (the rest overflow). bad inverts the checksum byte.
  task automatic gen_frame(input logic [7:0] cmd, input logic [7:0] lenb, input logic [7:0] seed,
                           input int keep, input bit bad);
    int          nw;
    logic [7:0]  chk;
    logic [7:0]  b;
    logic [31:0] w;
    nw  = (lenb == 8'd0) ? 256 : int'(lenb);
    chk = cmd ^ lenb;
    tx_q = {8'hA5, cmd, lenb};
    exp_cmds.push_back({cmd, 9'(nw)});
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = seed + 8'(4 * k + j);
        tx_q.push_back(b);
        chk ^= b;
        w[8*j +: 8] = b;
      end
      if (k < keep) exp_words.push_back({(k == nw - 1), w});
    end
    tx_q.push_back(bad ? ~chk : chk);
    if (keep < nw)  exp_done.push_back(3'b111);
    else if (bad)   exp_done.push_back(3'b101);
    else            exp_done.push_back(3'b000);
    send_tx();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_word_valid", 64'(word_valid), 64'd0);
    check("rst_word_data", 64'(word_data), 64'd0);
    check("rst_cmd_len", 64'(cmd_len), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);

    // 1: good single-word frame, CHK = 10^01^44^33^22^11 = 55
    exp_cmds.push_back({8'h10, 9'd1});
    exp_words.push_back({1'b1, 32'h11223344});
    exp_done.push_back(3'b000);
    tx_q = {8'hA5, 8'h10, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
    send_tx();
    wait_sb(20, 1'b0, "t1_drain");

    // 2: same frame, wrong checksum
    exp_cmds.push_back({8'h10, 9'd1});
    exp_words.push_back({1'b1, 32'h11223344});
    exp_done.push_back(3'b101);
    tx_q = {8'hA5, 8'h10, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    send_tx();
    wait_sb(20, 1'b0, "t2_drain");

    // 3: overflow with consumer stalled, then drain exactly 4 words
    word_ready = 1'b0;
    gen_frame(8'h30, 8'd6, 8'h00, 4, 1'b0);
    wait_sb(20, 1'b1, "t3_done");
    check("t3_buffered", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    wait_sb(20, 1'b0, "t3_drain");
    idle(2);
    check("t3_empty", 64'(word_valid), 64'd0);

    // 4: timeout inside payload, then a good frame
    exp_cmds.push_back({8'h01, 9'd2});
    exp_done.push_back(3'b110);
    tx_q = {8'hA5, 8'h01, 8'h02};
    send_tx();
    wait_sb(TO + 20, 1'b0, "t4_timeout");
    check("t4_busy", 64'(busy), 64'd0);
    gen_frame(8'h44, 8'd2, 8'h80, 2, 1'b0);
    wait_sb(20, 1'b0, "t4_after");

    // 5: noise ignored, good frame, then 256-word frame
    tx_q = {8'h00, 8'hFF, 8'h5A};
    send_tx();
    idle(3);
    check("t5_noise_busy", 64'(busy), 64'd0);
    exp_cmds.push_back({8'h10, 9'd1});
    exp_words.push_back({1'b1, 32'h11223344});
    exp_done.push_back(3'b000);
    tx_q = {8'hA5, 8'h10, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
    send_tx();
    wait_sb(20, 1'b0, "t5_frame");
    gen_frame(8'h77, 8'h00, 8'h10, 256, 1'b0);
    wait_sb(40, 1'b0, "t5_len256");

    // 6: reset mid-payload with words buffered
    word_ready = 1'b0;
    exp_cmds.push_back({8'h22, 9'd3});
    tx_q = {8'hA5, 8'h22, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_tx();
    idle(1);
    check("t6_pre_valid", 64'(word_valid), 64'd1);
    check("t6_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_word_valid", 64'(word_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_frame_done", 64'(frame_done), 64'd0);
    word_ready = 1'b1;
    gen_frame(8'h66, 8'd3, 8'h20, 3, 1'b0);
    wait_sb(20, 1'b0, "t6_after");
    idle(3);

    check("queues_empty", 64'(exp_cmds.size() + exp_words.size() + exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
